// File: rtl/cpu_rf_pkg.sv
// Register-file geometry shared by the CPU write-back path, plus the
// address-to-one-hot write-enable decoder.
package cpu_rf_pkg;

    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;
    localparam int DATA_W = 16;

    function automatic logic [NREG-1:0] onehot_dec(input logic [ADDR_W-1:0] addr);
        return NREG'(1) << addr;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then rotate the winner back to its absolute index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves a value unassigned and no latch is inferred.
        found   = 1'b0;
        gnt_idx = '0;
        dbl     = {req, req} >> ptr;
        rot     = dbl[N-1:0];
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found   = 1'b1;
                gnt_idx = IW'((int'(ptr) + k) % N);
            end
        end
        gnt = found ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: round-robin grant of the single register-file write
// port among NREQ sources, with a one-cycle registered write stage.
module regfile_wb_arbiter
    import cpu_rf_pkg::onehot_dec;
#(
    parameter int NREQ        = 4,
    parameter int DATA_W      = cpu_rf_pkg::DATA_W,
    parameter int ADDR_W      = cpu_rf_pkg::ADDR_W,
    parameter int NREG        = 2 ** ADDR_W,
    parameter bit ZERO_REG_RO = 1'b1,
    localparam int IDX_W      = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_stall,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   wr_en,
    output logic [NREG-1:0]        wr_sel,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [IDX_W-1:0]       grant_id
);

    localparam int PKG_AW = cpu_rf_pkg::ADDR_W;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic [NREQ-1:0]   pick_req;
    logic [NREQ-1:0]   pick_gnt;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;
    logic [NREG-1:0]   pick_sel;
    logic              transfer;
    logic              drop_write;

    assign pick_req = wb_stall ? '0 : req_valid;

    rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick (
        .req     (pick_req),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    // Gated by rst_n directly so grants vanish the instant reset asserts.
    assign req_ready  = rst_n ? pick_gnt : '0;
    assign transfer   = |req_ready;
    assign pick_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign pick_data  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    assign pick_sel   = NREG'(onehot_dec(PKG_AW'(pick_addr)));
    assign drop_write = ZERO_REG_RO && (pick_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            ptr      <= '0;
            wr_en    <= 1'b0;
            wr_sel   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else if (transfer) begin
            ptr      <= (pick_idx == IDX_W'(NREQ-1)) ? '0 : pick_idx + IDX_W'(1);
            wr_addr  <= pick_addr;
            wr_data  <= pick_data;
            grant_id <= pick_idx;
            // A write to a read-only r0 still consumes its grant slot.
            wr_en    <= !drop_write;
            wr_sel   <= drop_write ? '0 : pick_sel;
        end else begin
            wr_en    <= 1'b0;
            wr_sel   <= '0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grant order, registered write stage,
// stall gating, read-only r0 and asynchronous reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_stall;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        wr_en;
    logic [7:0]  wr_sel;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  grant_id;

    logic [29:0] obs;
    int          n_checks = 0;
    int          n_fail   = 0;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_stall  (wb_stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    assign obs = {wr_en, wr_sel, wr_addr, wr_data, grant_id};

    // Expected output tuple for a grant to requester g with the standard
    // table: address g+4, data 0x1000+g.
    function automatic logic [29:0] exp_write(input int g);
        return {1'b1, 8'(1) << (g + 4), 3'(g + 4), 16'(16'h1000 + g), 2'(g)};
    endfunction

    task automatic load_table();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*3 +: 3]   = 3'(i + 4);
            req_data[i*16 +: 16] = 16'(16'h1000 + i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        wb_stall  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        wb_stall  = 1'b0;
        req_valid = 4'b1111;
        req_addr  = '0;
        req_data  = '0;
        #3;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_checks++;
        if (obs !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, 30'h0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid          = 4'b0001;
        req_addr[2:0]      = 3'd3;
        req_data[15:0]     = 16'h00A5;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== {1'b1, 8'h08, 3'd3, 16'h00A5, 2'd0}) begin
            n_fail++;
            $display("FAIL single_write: got %h want %h", obs, {1'b1, 8'h08, 3'd3, 16'h00A5, 2'd0});
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 0000", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== {1'b0, 8'h00, 3'd3, 16'h00A5, 2'd0}) begin
            n_fail++;
            $display("FAIL idle_hold: got %h want %h", obs, {1'b0, 8'h00, 3'd3, 16'h00A5, 2'd0});
        end
    endtask

    task automatic test_rotation();
        do_reset();
        load_table();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL rotate_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_write(k % 4)) begin
                n_fail++;
                $display("FAIL rotate_write[%0d]: got %h want %h", k, obs, exp_write(k % 4));
            end
        end
    endtask

    task automatic test_skip();
        logic [3:0] valids [4] = '{4'b0010, 4'b1010, 4'b1010, 4'b1111};
        int         grants [4] = '{1, 3, 1, 2};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = valids[k];
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << grants[k])) begin
                n_fail++;
                $display("FAIL skip_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << grants[k]));
            end
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_write(grants[k])) begin
                n_fail++;
                $display("FAIL skip_write[%0d]: got %h want %h", k, obs, exp_write(grants[k]));
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            wb_stall  = 1'b1;
            req_valid = 4'b1111;
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", k, req_ready);
            end
            if (k == 0) begin
                n_checks++;
                if (wr_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_inflight: got wr_en=%b want 1", wr_en);
                end
            end
            @(posedge clk); #1;
            n_checks++;
            if (obs !== {1'b0, 8'h00, 3'd6, 16'h1002, 2'd2}) begin
                n_fail++;
                $display("FAIL stall_write[%0d]: got %h want %h", k, obs, {1'b0, 8'h00, 3'd6, 16'h1002, 2'd2});
            end
        end
        @(negedge clk);
        wb_stall = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL unstall_ready: got %b want 1000", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== exp_write(3)) begin
            n_fail++;
            $display("FAIL unstall_write: got %h want %h", obs, exp_write(3));
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        req_valid        = 4'b0100;
        req_addr[8:6]    = 3'd0;
        req_data[47:32]  = 16'hFFFF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL zero_ready: got %b want 0100", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== {1'b0, 8'h00, 3'd0, 16'hFFFF, 2'd2}) begin
            n_fail++;
            $display("FAIL zero_write: got %h want %h", obs, {1'b0, 8'h00, 3'd0, 16'hFFFF, 2'd2});
        end
        @(negedge clk);
        load_table();
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL zero_ptr: got %b want 1000", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== exp_write(3)) begin
            n_fail++;
            $display("FAIL zero_next_write: got %h want %h", obs, exp_write(3));
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL pre_reset_ready: got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== exp_write(0)) begin
            n_fail++;
            $display("FAIL pre_reset_write: got %h want %h", obs, exp_write(0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_ready: got %b want 0000", req_ready);
        end
        n_checks++;
        if (obs !== 30'h0) begin
            n_fail++;
            $display("FAIL async_outputs: got %h want %h", obs, 30'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_ptr: got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== exp_write(0)) begin
            n_fail++;
            $display("FAIL post_reset_write: got %h want %h", obs, exp_write(0));
        end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_skip();
        test_stall();
        test_zero_reg();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
